// File: rtl/ifu_axi_rd_sram_if.sv
// AXI4 read-address and read-data channels between the IFU fetch master and
// the instruction memory model.
interface ifu_axi_rd_sram_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ifu_axi_rd_sram.sv
// AXI4 read-only instruction memory: one burst at a time, fixed start latency,
// DECERR/SLVERR for bad requests, backdoor load port.
// Define RD_LAT_RAND_EN to add an LFSR-driven 0..7 cycle jitter on the latency.
module ifu_axi_rd_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h80000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  ifu_axi_rd_sram_if.slave  bus,
  input  logic              bd_wen,
  input  logic [IDX_W-1:0]  bd_widx,
  input  logic [31:0]       bd_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  state_t      state, next_state;
  logic [4:0]  cnt, next_cnt, lat_load;
  logic        next_arready, next_rvalid, next_rlast;
  logic        capture, load;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cap_addr;
  logic [7:0]  cap_len;
  logic [1:0]  cap_burst;
  logic [7:0]  beat_idx;

  logic [31:0] beat_addr, beat_off, beat_data;
  logic [1:0]  beat_resp;
  logic [IDX_W-1:0] beat_word;
  logic        in_range, is_last;

  // Error responses are decided per beat so an INCR burst can run off the top.
  function automatic logic [1:0] resp_of(input logic [1:0] burst, input logic ok);
    if (burst[1])
      return RESP_SLVERR;
    else if (!ok)
      return RESP_DECERR;
    else
      return RESP_OKAY;
  endfunction

`ifdef RD_LAT_RAND_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 8'hA5;
    else
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_load = 5'(LATENCY) + {2'b00, lfsr[2:0]};
`else
  assign lat_load = 5'(LATENCY);
`endif

  always_comb begin
    beat_addr = cap_addr;
    if (cap_burst == 2'b01)
      beat_addr = cap_addr + 32'({beat_idx, 2'b00});
    beat_off  = beat_addr - ADDR_BASE;
    in_range  = {1'b0, beat_off} < SPAN;
    beat_word = beat_off[IDX_W+1:2];
    beat_resp = resp_of(cap_burst, in_range);
    beat_data = (beat_resp == RESP_OKAY) ? mem[beat_word] : 32'h0;
    is_last   = (beat_idx == cap_len);
  end

  logic unused_bits;
  assign unused_bits = ^{bus.arsize, bus.araddr[1:0], beat_off[1:0], beat_off[31:IDX_W+2]};

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_arready = bus.arready;
    next_rvalid  = bus.rvalid;
    next_rlast   = bus.rlast;
    capture      = 1'b0;
    load         = 1'b0;
    case (state)
      IDLE: begin
        next_arready = 1'b1;
        if (bus.arvalid && bus.arready) begin
          capture      = 1'b1;
          next_arready = 1'b0;
          next_cnt     = lat_load;
          next_state   = WAIT;
        end
      end
      WAIT: begin
        next_arready = 1'b0;
        if (cnt == 5'd0) begin
          load        = 1'b1;
          next_rvalid = 1'b1;
          next_rlast  = is_last;
          next_state  = DATA;
        end else begin
          next_cnt = cnt - 5'd1;
        end
      end
      DATA: begin
        // arready rises on the last-beat edge so the next AR lands one cycle later.
        if (bus.rready) begin
          if (bus.rlast) begin
            next_rvalid  = 1'b0;
            next_rlast   = 1'b0;
            next_arready = 1'b1;
            next_state   = IDLE;
          end else begin
            load       = 1'b1;
            next_rlast = is_last;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rlast   <= 1'b0;
      bus.rresp   <= RESP_OKAY;
      bus.rid     <= 4'd0;
      bus.rdata   <= 32'h0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      bus.arready <= next_arready;
      bus.rvalid  <= next_rvalid;
      bus.rlast   <= next_rlast;
      if (capture)
        bus.rid <= bus.arid;
      if (load) begin
        bus.rdata <= beat_data;
        bus.rresp <= beat_resp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cap_addr  <= {bus.araddr[31:2], 2'b00};
      cap_len   <= bus.arlen;
      cap_burst <= bus.arburst;
      beat_idx  <= 8'd0;
    end else if (load) begin
      beat_idx  <= beat_idx + 8'd1;
    end
  end

  // Nonblocking write gives read-before-write against a same-edge beat load.
  always_ff @(posedge clk) begin
    if (bd_wen)
      mem[bd_widx] <= bd_wdata;
  end

endmodule

// File: tb/tb_ifu_axi_rd_sram.sv
// Directed bench for ifu_axi_rd_sram with LATENCY=2 and 1024 words at 0x80000000.
module tb_ifu_axi_rd_sram;
  logic clk = 1'b0;
  logic rst;
  logic bd_wen;
  logic [9:0] bd_widx;
  logic [31:0] bd_wdata;
  int checks = 0;
  int errors = 0;

  ifu_axi_rd_sram_if bus();

  ifu_axi_rd_sram #(
    .ADDR_BASE(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .bd_wen(bd_wen), .bd_widx(bd_widx), .bd_wdata(bd_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [9:0] idx, input logic [31:0] data);
    bd_wen = 1'b1; bd_widx = idx; bd_wdata = data;
    step();
    bd_wen = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id);
    logic hs;
    int n;
    hs = 1'b0; n = 0;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len;
    bus.arburst = burst; bus.arid = id; bus.arsize = 3'd2;
    while (!hs && n < 50) begin
      hs = bus.arready;
      step();
      n++;
    end
    bus.arvalid = 1'b0;
    bus.araddr  = 32'hDEADBEEF;
    check("ar_handshake", {31'd0, hs}, 32'd1);
    check("arready_low_after_hs", {31'd0, bus.arready}, 32'd0);
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    while (!bus.rvalid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
    check({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
    check({tag, "_rdata"},  bus.rdata, data);
    check({tag, "_rresp"},  {30'd0, bus.rresp}, {30'd0, resp});
    check({tag, "_rlast"},  {31'd0, bus.rlast}, {31'd0, last});
  endtask

  initial begin
    int lat;
    rst = 1'b1; bd_wen = 1'b0; bd_widx = '0; bd_wdata = '0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = 2'b01; bus.rready = 1'b1;
    repeat (3) step();

    check("rst_arready", {31'd0, bus.arready}, 32'd0);
    check("rst_rvalid",  {31'd0, bus.rvalid}, 32'd0);
    check("rst_rlast",   {31'd0, bus.rlast}, 32'd0);
    check("rst_rresp",   {30'd0, bus.rresp}, 32'd0);
    check("rst_rid",     {28'd0, bus.rid}, 32'd0);
    check("rst_rdata",   bus.rdata, 32'd0);

    // memory loads happen while still in reset
    bd_write(10'd0, 32'h00000413);
    bd_write(10'd4, 32'd1);
    bd_write(10'd5, 32'd2);
    bd_write(10'd6, 32'd3);
    bd_write(10'd7, 32'd4);
    bd_write(10'd1023, 32'hCAFEF00D);

    rst = 1'b0;
    step();
    check("arready_after_rst", {31'd0, bus.arready}, 32'd1);

    // single beat, latency 2 -> rvalid three edges after handshake
    ar_issue(32'h80000000, 8'd0, 2'b01, 4'd3);
    wait_rvalid(lat);
    check("t1_latency", lat, 32'd3);
    check_beat("t1", 32'h00000413, 2'b00, 1'b1);
    check("t1_rid", {28'd0, bus.rid}, 32'd3);
    step();
    check("t1_rvalid_done", {31'd0, bus.rvalid}, 32'd0);
    check("t1_arready_back", {31'd0, bus.arready}, 32'd1);

    // INCR 4 beats with a 2-cycle stall on beat 1
    ar_issue(32'h80000010, 8'd3, 2'b01, 4'd5);
    wait_rvalid(lat);
    check("t2_latency", lat, 32'd3);
    check_beat("t2_b1", 32'd1, 2'b00, 1'b0);
    bus.rready = 1'b0;
    step();
    check_beat("t2_stall1", 32'd1, 2'b00, 1'b0);
    step();
    check_beat("t2_stall2", 32'd1, 2'b00, 1'b0);
    check("t2_rid", {28'd0, bus.rid}, 32'd5);
    bus.rready = 1'b1;
    step();
    check_beat("t2_b2", 32'd2, 2'b00, 1'b0);
    step();
    check_beat("t2_b3", 32'd3, 2'b00, 1'b0);
    step();
    check_beat("t2_b4", 32'd4, 2'b00, 1'b1);
    step();
    check("t2_rvalid_done", {31'd0, bus.rvalid}, 32'd0);
    check("t2_arready_back", {31'd0, bus.arready}, 32'd1);

    // just below the base
    ar_issue(32'h7FFFFFFC, 8'd0, 2'b01, 4'd1);
    wait_rvalid(lat);
    check_beat("t3", 32'd0, 2'b11, 1'b1);
    step();

    // INCR across the top boundary
    ar_issue(32'h80000FFC, 8'd1, 2'b01, 4'd2);
    wait_rvalid(lat);
    check_beat("t4_b0", 32'hCAFEF00D, 2'b00, 1'b0);
    step();
    check_beat("t4_b1", 32'd0, 2'b11, 1'b1);
    step();

    // unsupported burst type
    ar_issue(32'h80000000, 8'd1, 2'b10, 4'd7);
    wait_rvalid(lat);
    check_beat("t5_b0", 32'd0, 2'b10, 1'b0);
    step();
    check_beat("t5_b1", 32'd0, 2'b10, 1'b1);
    check("t5_rid", {28'd0, bus.rid}, 32'd7);
    step();

    // reset in the middle of a 4-beat burst
    ar_issue(32'h80000010, 8'd3, 2'b01, 4'd9);
    wait_rvalid(lat);
    step();
    check_beat("t6_b2", 32'd2, 2'b00, 1'b0);
    rst = 1'b1;
    step();
    check("t6_rvalid_rst", {31'd0, bus.rvalid}, 32'd0);
    check("t6_arready_rst", {31'd0, bus.arready}, 32'd0);
    rst = 1'b0;
    step();
    check("t6_arready_release", {31'd0, bus.arready}, 32'd1);
    ar_issue(32'h80000014, 8'd0, 2'b00, 4'd4);
    wait_rvalid(lat);
    check("t6_latency", lat, 32'd3);
    check_beat("t6_new", 32'd2, 2'b00, 1'b1);
    check("t6_rid", {28'd0, bus.rid}, 32'd4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
